// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared widths and FSM state type for the UART word scheduler
package uart_sched_pkg;
    localparam int UART_BYTE_W = 8;
    localparam int UART_WORD_W = 16;
    typedef enum logic [1:0] {IDLE, SEND_MSB, SEND_LSB, GAP} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin selector
//   clk, rst_n : clock, async active-low reset (priority returns to requester 0)
//   req[1:0]   : request lines
//   upd        : a grant was taken this cycle, so rotate priority away from the winner
//   gnt[1:0]   : one-hot grant, or zero when nobody requests
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);
    logic r_prio;

    // r_prio names the requester that wins a tie; a lone requester always wins
    always_comb gnt = (req == 2'b11) ? (r_prio ? 2'b10 : 2'b01) : req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_prio <= 1'b0;
        else if (upd && |gnt)
            r_prio <= gnt[0];
    end
endmodule

// File: rtl/uart_word_sched.sv
// uart_word_sched: arbitrates two 16-bit word requesters and serialises each word
// MSB byte first into a byte-wide UART transmitter handshake, with an optional
// idle gap after every word.
//   clk, rst_n                        : clock, async active-low reset
//   req0_valid/req0_data/req0_ready   : requester 0 word handshake
//   req1_valid/req1_data/req1_ready   : requester 1 word handshake
//   byte_valid/byte_data/byte_ready   : downstream byte handshake
//   busy                              : scheduler is not idle
//   grant_id                          : requester owning the current/last word
//   words_sent                        : words completed (only with UART_WORD_SCHED_STATS_EN)
module uart_word_sched
    import uart_sched_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic [UART_WORD_W-1:0] req0_data,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [UART_WORD_W-1:0] req1_data,
    output logic                   req1_ready,
    output logic                   byte_valid,
    output logic [UART_BYTE_W-1:0] byte_data,
    input  logic                   byte_ready,
    output logic                   busy,
    output logic                   grant_id
`ifdef UART_WORD_SCHED_STATS_EN
    ,
    output logic [15:0]            words_sent
`endif
);
    state_t                 r_state, w_next;
    logic [UART_WORD_W-1:0] r_word;
    logic [7:0]             r_gap_cnt;
    logic                   r_grant;
    logic [1:0]             w_gnt;
    logic                   w_accept;
    logic                   w_lsb_done;

    assign w_accept   = (r_state == IDLE) && |w_gnt;
    assign w_lsb_done = (r_state == SEND_LSB) && byte_ready;
    assign busy       = r_state != IDLE;
    assign grant_id   = r_grant;

    rr_arb2 u_arb (
        .clk (clk),
        .rst_n (rst_n),
        .req ({req1_valid, req0_valid}),
        .upd (w_accept),
        .gnt (w_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        case (r_state)
            IDLE: begin
                req0_ready = w_gnt[0];
                req1_ready = w_gnt[1];
                if (|w_gnt) w_next = SEND_MSB;
            end
            SEND_MSB: begin
                byte_valid = 1'b1;
                byte_data  = r_word[15:8];
                if (byte_ready) w_next = SEND_LSB;
            end
            SEND_LSB: begin
                byte_valid = 1'b1;
                byte_data  = r_word[7:0];
                if (byte_ready) w_next = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
                // counter is loaded with GAP_CYCLES, so leaving at 1 gives exactly GAP_CYCLES cycles here
                if (r_gap_cnt <= 8'd1) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word    <= '0;
            r_grant   <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_word  <= w_gnt[1] ? req1_data : req0_data;
                r_grant <= w_gnt[1];
            end
            if (w_lsb_done)
                r_gap_cnt <= 8'(GAP_CYCLES);
            else if (r_state == GAP)
                r_gap_cnt <= r_gap_cnt - 8'd1;
        end
    end

`ifdef UART_WORD_SCHED_STATS_EN
    logic [15:0] r_words_sent;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_words_sent <= '0;
        else if (w_lsb_done)
            r_words_sent <= r_words_sent + 16'd1;
    end

    assign words_sent = r_words_sent;
`endif
endmodule

// File: tb/tb_uart_word_sched.sv
// tb_uart_word_sched: scoreboard bench for uart_word_sched (GAP_CYCLES=0 and GAP_CYCLES=4 instances)
module tb_uart_word_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, byte_ready = 1'b0;
    logic [15:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, byte_valid, busy, grant_id;
    logic [7:0]  byte_data;
    logic        g_req0_valid = 1'b0, g_byte_ready = 1'b0;
    logic [15:0] g_req0_data = '0;
    logic        g_req0_ready, g_req1_ready, g_byte_valid, g_busy, g_grant_id;
    logic [7:0]  g_byte_data;
`ifdef UART_WORD_SCHED_STATS_EN
    logic [15:0] words_sent, g_words_sent;
`endif
    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  sb[$];

    always #5 clk = ~clk;

    uart_word_sched #(.GAP_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .busy(busy), .grant_id(grant_id)
`ifdef UART_WORD_SCHED_STATS_EN
        , .words_sent(words_sent)
`endif
    );

    uart_word_sched #(.GAP_CYCLES(4)) dut_gap (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(g_req0_valid), .req0_data(g_req0_data), .req0_ready(g_req0_ready),
        .req1_valid(1'b0), .req1_data(16'h0000), .req1_ready(g_req1_ready),
        .byte_valid(g_byte_valid), .byte_data(g_byte_data), .byte_ready(g_byte_ready),
        .busy(g_busy), .grant_id(g_grant_id)
`ifdef UART_WORD_SCHED_STATS_EN
        , .words_sent(g_words_sent)
`endif
    );

    // byte stream scoreboard: every transmitter acceptance must match the next expected byte
    always @(negedge clk) begin
        if (rst_n && byte_valid && byte_ready) begin
            n_checks++;
            if (sb.size() == 0)
                $display("FAIL sb_unexpected: got byte %h, expected no byte", byte_data);
            else begin
                logic [7:0] exp_b;
                exp_b = sb.pop_front();
                if (byte_data !== exp_b)
                    $display("FAIL sb_byte: got %h expected %h", byte_data, exp_b);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL %s_drain: got %0d pending bytes expected 0", name, sb.size());
        else
            n_pass++;
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if ({byte_valid, busy, grant_id, req0_ready, req1_ready} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000", {byte_valid, busy, grant_id, req0_ready, req1_ready});
        else
            n_pass++;
        n_checks++;
        if (byte_data !== 8'h00)
            $display("FAIL reset_data: got %h expected 00", byte_data);
        else
            n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || byte_valid !== 1'b0)
            $display("FAIL reset_release: got busy=%b valid=%b expected 0 0", busy, byte_valid);
        else
            n_pass++;
    endtask

    task automatic test_single;
        byte_ready = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 16'hDE01;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL single_ready: got %b%b expected 01", req1_ready, req0_ready);
        else
            n_pass++;
        sb.push_back(8'hDE);
        sb.push_back(8'h01);
        tick();
        req0_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || grant_id !== 1'b0 || byte_data !== 8'hDE)
            $display("FAIL single_msb: got busy=%b gid=%b data=%h expected 1 0 de", busy, grant_id, byte_data);
        else
            n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b1 || byte_data !== 8'h01)
            $display("FAIL single_lsb: got busy=%b data=%h expected 1 01", busy, byte_data);
        else
            n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0 || byte_valid !== 1'b0)
            $display("FAIL single_done: got busy=%b valid=%b expected 0 0", busy, byte_valid);
        else
            n_pass++;
        check_drained("single");
    endtask

    task automatic test_round_robin;
        do_reset();
        byte_ready = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 16'h1234;
        req1_valid = 1'b1;
        req1_data  = 16'hABCD;
        for (int w = 0; w < 4; w++) begin
            sb.push_back(w[0] ? 8'hAB : 8'h12);
            sb.push_back(w[0] ? 8'hCD : 8'h34);
        end
        for (int w = 0; w < 4; w++) begin
            tick();
            n_checks++;
            if (grant_id !== w[0])
                $display("FAIL rr_grant%0d: got %b expected %b", w, grant_id, w[0]);
            else
                n_pass++;
            n_checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
                $display("FAIL rr_busy_ready%0d: got %b%b expected 00", w, req1_ready, req0_ready);
            else
                n_pass++;
            if (w == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            tick();
            tick();
        end
        check_drained("rr");
    endtask

    task automatic test_stall;
        byte_ready = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 16'h55AA;
        sb.push_back(8'h55);
        sb.push_back(8'hAA);
        sb.push_back(8'h77);
        sb.push_back(8'h88);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 16'h7788;
        n_checks++;
        if (grant_id !== 1'b1)
            $display("FAIL stall_grant: got %b expected 1", grant_id);
        else
            n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (byte_valid !== 1'b1 || byte_data !== 8'h55)
                $display("FAIL stall_hold%0d: got valid=%b data=%h expected 1 55", i, byte_valid, byte_data);
            else
                n_pass++;
            n_checks++;
            if (req0_ready !== 1'b0)
                $display("FAIL stall_ready%0d: got %b expected 0", i, req0_ready);
            else
                n_pass++;
            tick();
        end
        byte_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (req0_ready !== 1'b1)
            $display("FAIL stall_wait_accept: got %b expected 1", req0_ready);
        else
            n_pass++;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        check_drained("stall");
    endtask

    task automatic test_idle_ready;
        byte_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (byte_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL idle_ready%0d: got valid=%b busy=%b expected 0 0", i, byte_valid, busy);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        byte_ready = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 16'hBEEF;
        sb.push_back(8'hBE);
        tick();
        req0_valid = 1'b0;
        tick();
        n_checks++;
        if (byte_valid !== 1'b1 || byte_data !== 8'hEF)
            $display("FAIL midrst_lsb: got valid=%b data=%h expected 1 ef", byte_valid, byte_data);
        else
            n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (byte_valid !== 1'b0 || busy !== 1'b0 || byte_data !== 8'h00)
            $display("FAIL midrst_async: got valid=%b busy=%b data=%h expected 0 0 00", byte_valid, busy, byte_data);
        else
            n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        check_drained("midrst_discard");
        req0_valid = 1'b1;
        req0_data  = 16'h0102;
        sb.push_back(8'h01);
        sb.push_back(8'h02);
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        check_drained("midrst_after");
    endtask

    task automatic test_gap;
        int acc[$];
        int gap_cnt = 0;
        logic [7:0] first_byte = 8'h00;
        logic got_first = 1'b0;
        g_byte_ready = 1'b1;
        g_req0_valid = 1'b1;
        g_req0_data  = 16'hC35A;
        for (int c = 0; c < 40 && acc.size() < 3; c++) begin
            if (g_req0_valid && g_req0_ready) acc.push_back(c);
            if (acc.size() == 1 && g_busy && !g_byte_valid) gap_cnt++;
            if (g_byte_valid && !got_first) begin
                first_byte = g_byte_data;
                got_first  = 1'b1;
            end
            tick();
        end
        g_req0_valid = 1'b0;
        n_checks++;
        if (acc.size() < 3)
            $display("FAIL gap_timeout: got %0d accepts expected 3", acc.size());
        else begin
            n_pass++;
            n_checks++;
            if (acc[1] - acc[0] != 7 || acc[2] - acc[1] != 7)
                $display("FAIL gap_period: got %0d,%0d expected 7,7", acc[1] - acc[0], acc[2] - acc[1]);
            else
                n_pass++;
        end
        n_checks++;
        if (gap_cnt != 4)
            $display("FAIL gap_cycles: got %0d expected 4", gap_cnt);
        else
            n_pass++;
        n_checks++;
        if (first_byte !== 8'hC3)
            $display("FAIL gap_msb: got %h expected c3", first_byte);
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_idle_ready();
        test_reset_mid();
        test_gap();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
